// File: rtl/sdram_if.sv
// Command/data bus between an SDRAM controller (master) and the sdram_responder
// device model (slave).
interface sdram_if;
    // No handshake: the slave samples a command on every rising edge where
    // CKE=1 and nCS=0; there is no backpressure. burst_state is debug
    // visibility of the responder's burst engine.
    logic        SDRAM_CKE;
    logic        SDRAM_nCS;
    logic        SDRAM_nRAS;
    logic        SDRAM_nCAS;
    logic        SDRAM_nWE;
    logic [1:0]  SDRAM_BA;
    logic [12:0] SDRAM_A;
    logic [1:0]  SDRAM_DQM;
    logic [15:0] dq_in;
    logic [15:0] dq_out;
    logic [1:0]  dq_oe;
    logic        mode_set;
    logic        protocol_err;
    logic [1:0]  burst_state;

    modport master (
        output SDRAM_CKE, SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE,
        output SDRAM_BA, SDRAM_A, SDRAM_DQM, dq_in,
        input  dq_out, dq_oe, mode_set, protocol_err, burst_state
    );

    modport slave (
        input  SDRAM_CKE, SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE,
        input  SDRAM_BA, SDRAM_A, SDRAM_DQM, dq_in,
        output dq_out, dq_oe, mode_set, protocol_err, burst_state
    );
endinterface

// File: rtl/sdram_responder.sv
// Behavioural SDRAM device responder: banks, mode register, bursts, CL pipeline.
// Define SDRAM_RESP_TIMING_CHECK_EN to add tRCD/tRP/tRFC violation checking.
module sdram_responder #(
    parameter int ROW_BITS = 2,
    parameter int T_RCD    = 2,
    parameter int T_RP     = 2,
    parameter int T_RFC    = 7
) (
    input logic    clk,
    input logic    reset_n,
    sdram_if.slave bus
);

    localparam int AW = 2 + ROW_BITS + 9;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_READ = 2'd1, ST_WRITE = 2'd2} state_t;

    logic [15:0] mem [0:(1<<AW)-1];

    logic [1:0]  ba;
    logic [12:0] a;
    logic [2:0]  cmd;
    logic        cmd_v, is_act, is_rd, is_wr, is_bt, is_pre, is_ref, is_lmr;

    assign ba    = bus.SDRAM_BA;
    assign a     = bus.SDRAM_A;
    assign cmd   = {bus.SDRAM_nRAS, bus.SDRAM_nCAS, bus.SDRAM_nWE};
    assign cmd_v = bus.SDRAM_CKE && !bus.SDRAM_nCS;
    assign is_act = cmd_v && (cmd == 3'b011);
    assign is_rd  = cmd_v && (cmd == 3'b101);
    assign is_wr  = cmd_v && (cmd == 3'b100);
    assign is_bt  = cmd_v && (cmd == 3'b110);
    assign is_pre = cmd_v && (cmd == 3'b010);
    assign is_ref = cmd_v && (cmd == 3'b001);
    assign is_lmr = cmd_v && (cmd == 3'b000);

    state_t              state;
    logic [3:0]          bank_open;
    logic [ROW_BITS-1:0] bank_row [4];
    logic [3:0]          mode_bl;
    logic                mode_cl2, mode_wr_single, mode_set_q;
    logic [1:0]          bst_ba;
    logic [ROW_BITS-1:0] bst_row;
    logic [8:0]          bst_col;
    logic [3:0]          bst_k, bst_len;
    logic                bst_ap;
    logic                p1_v, p2_v;
    logic [AW-1:0]       p1_addr, p2_addr;
    logic [1:0]          dqm_d;
    logic [15:0]         dq_out_q;
    logic [1:0]          dq_oe_q;
    logic                perr_q;

    logic                acc, err_state, err_timing, rd_cancel, beat_rd, beat_wr, beat_last;
    logic [3:0]          new_len;
    logic [1:0]          beat_ba;
    logic [ROW_BITS-1:0] beat_row;
    logic [8:0]          beat_col;
    logic [AW-1:0]       beat_addr, src_addr;
    logic                src_v;

    // Sequential order inside the BL-aligned block: the low bits count and wrap.
    function automatic logic [8:0] wrap_col(input logic [8:0] base, input logic [3:0] k,
                                            input logic [3:0] len);
        logic [8:0] mask;
        mask = {5'd0, len - 4'd1};
        return (base & ~mask) | ((base + {5'd0, k}) & mask);
    endfunction

    always_comb begin
        acc       = (is_rd || is_wr) && mode_set_q && bank_open[ba];
        err_state = ((is_rd || is_wr) && !acc) || (is_act && bank_open[ba]) ||
                    (is_ref && (|bank_open));
        rd_cancel = acc && is_wr;
        new_len   = (is_wr && mode_wr_single) ? 4'd1 : mode_bl;
        beat_rd   = 1'b0;
        beat_wr   = 1'b0;
        beat_ba   = bst_ba;
        beat_row  = bst_row;
        beat_col  = wrap_col(bst_col, bst_k, bst_len);
        beat_last = (bst_k + 4'd1 == bst_len);
        if (acc) begin
            beat_ba  = ba;
            beat_row = bank_row[ba];
            beat_col = a[8:0];
            beat_rd  = is_rd;
            beat_wr  = is_wr;
        end else if (!is_bt) begin
            beat_rd = (state == ST_READ);
            beat_wr = (state == ST_WRITE);
        end
        beat_addr = {beat_ba, beat_row, beat_col};
        src_v     = mode_cl2 ? p1_v : p2_v;
        src_addr  = mode_cl2 ? p1_addr : p2_addr;
    end

`ifdef SDRAM_RESP_TIMING_CHECK_EN
    // Counters hold cycles elapsed since the event, saturating; 1 on the next edge.
    logic [7:0] act_cnt [4];
    logic [7:0] pre_cnt [4];
    logic [7:0] rfc_cnt;

    always_comb begin
        err_timing = 1'b0;
        if ((is_rd || is_wr) && act_cnt[ba] < 8'(T_RCD)) err_timing = 1'b1;
        if (is_act && pre_cnt[ba] < 8'(T_RP))             err_timing = 1'b1;
        if (cmd_v && cmd != 3'b111 && rfc_cnt < 8'(T_RFC)) err_timing = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                act_cnt[i] <= 8'hFF;
                pre_cnt[i] <= 8'hFF;
            end
            rfc_cnt <= 8'hFF;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (act_cnt[i] != 8'hFF) act_cnt[i] <= act_cnt[i] + 8'd1;
                if (pre_cnt[i] != 8'hFF) pre_cnt[i] <= pre_cnt[i] + 8'd1;
                if (is_pre && a[10])     pre_cnt[i] <= 8'd1;
            end
            if (rfc_cnt != 8'hFF) rfc_cnt <= rfc_cnt + 8'd1;
            if (is_act)               act_cnt[ba] <= 8'd1;
            if (is_pre && !a[10])     pre_cnt[ba] <= 8'd1;
            if (is_ref)               rfc_cnt     <= 8'd1;
        end
    end
`else
    assign err_timing = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{a[12:11], a[3], 8'(T_RCD + T_RP + T_RFC)};

    // Storage is never reset; a write beat on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (reset_n && beat_wr) begin
            if (!bus.SDRAM_DQM[0]) mem[beat_addr][7:0]  <= bus.dq_in[7:0];
            if (!bus.SDRAM_DQM[1]) mem[beat_addr][15:8] <= bus.dq_in[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            bank_open      <= 4'd0;
            for (int i = 0; i < 4; i++) bank_row[i] <= '0;
            mode_bl        <= 4'd1;
            mode_cl2       <= 1'b0;
            mode_wr_single <= 1'b0;
            mode_set_q     <= 1'b0;
            bst_ba         <= 2'd0;
            bst_row        <= '0;
            bst_col        <= 9'd0;
            bst_k          <= 4'd0;
            bst_len        <= 4'd1;
            bst_ap         <= 1'b0;
            p1_v           <= 1'b0;
            p2_v           <= 1'b0;
            p1_addr        <= '0;
            p2_addr        <= '0;
            dqm_d          <= 2'd0;
            dq_out_q       <= 16'd0;
            dq_oe_q        <= 2'd0;
            perr_q         <= 1'b0;
        end else begin
            perr_q <= err_state || err_timing;
            dqm_d  <= bus.SDRAM_DQM;

            if (acc) begin
                bst_ba  <= ba;
                bst_row <= bank_row[ba];
                bst_col <= a[8:0];
                bst_len <= new_len;
                bst_k   <= 4'd1;
                bst_ap  <= a[10];
                if (new_len == 4'd1) begin
                    state <= ST_IDLE;
                    if (a[10]) bank_open[ba] <= 1'b0;
                end else begin
                    state <= is_rd ? ST_READ : ST_WRITE;
                end
            end else if (is_bt) begin
                state <= ST_IDLE;
            end else if (state != ST_IDLE) begin
                bst_k <= bst_k + 4'd1;
                if (beat_last) begin
                    state <= ST_IDLE;
                    if (bst_ap) bank_open[bst_ba] <= 1'b0;
                end
            end

            if (is_act && !bank_open[ba]) begin
                bank_open[ba] <= 1'b1;
                bank_row[ba]  <= a[ROW_BITS-1:0];
            end
            if (is_pre) begin
                if (a[10]) bank_open     <= 4'd0;
                else       bank_open[ba] <= 1'b0;
            end
            if (is_lmr) begin
                mode_set_q     <= 1'b1;
                mode_cl2       <= (a[6:4] == 3'd2);
                mode_wr_single <= a[9];
                case (a[2:0])
                    3'd1:    mode_bl <= 4'd2;
                    3'd2:    mode_bl <= 4'd4;
                    3'd3:    mode_bl <= 4'd8;
                    default: mode_bl <= 4'd1;
                endcase
            end

            // Two-stage CL delay line; CL2 taps stage 1, CL3 taps stage 2.
            p1_v    <= beat_rd;
            p1_addr <= beat_addr;
            p2_v    <= p1_v && !rd_cancel;
            p2_addr <= p1_addr;
            if (!rd_cancel && src_v) begin
                dq_oe_q  <= ~dqm_d;
                dq_out_q <= mem[src_addr] & {{8{~dqm_d[1]}}, {8{~dqm_d[0]}}};
            end else begin
                dq_oe_q  <= 2'd0;
                dq_out_q <= 16'd0;
            end
        end
    end

    assign bus.dq_out       = dq_out_q;
    assign bus.dq_oe        = dq_oe_q;
    assign bus.mode_set     = mode_set_q;
    assign bus.protocol_err = perr_q;
    assign bus.burst_state  = state;

endmodule

// File: doc/sdram_responder.md
SDRAM_RESPONDER -- requirements
Module: sdram_responder

Interface
REQ-001 SHALL have parameter ROW_BITS, default 2: low row-address bits that index the backing store.
REQ-002 SHALL have parameter T_RCD, default 2: minimum cycles from ACTIVE to READ/WRITE in the same bank.
REQ-003 SHALL have parameter T_RP, default 2: minimum cycles from PRECHARGE to ACTIVE.
REQ-004 SHALL have parameter T_RFC, default 7: minimum cycles from AUTO REFRESH to the next non-NOP command.
REQ-005 SHALL have these ports, one per line:
- clk  in  1  single clock; all device-side inputs sampled on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- SDRAM_CKE  in  1  clock enable; low means the command is ignored.
- SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE  in  1 each  command bus.
- SDRAM_BA  in  2  bank address.
- SDRAM_A  in  13  row, column or mode address.
- SDRAM_DQM  in  2  byte masks.
- dq_in  in  16  write data from the controller.
- dq_out  out  16  read data.
- dq_oe  out  2  per-byte output enable.
- mode_set  out  1  high once any LOAD MODE has been accepted.
- protocol_err  out  1  one-cycle pulse on an illegal command.

Function
REQ-006 SHALL decode {nRAS,nCAS,nWE} only when CKE=1 and nCS=0: 111 NOP, 011 ACTIVE, 101 READ, 100 WRITE, 110 BURST TERMINATE, 010 PRECHARGE, 001 AUTO REFRESH, 000 LOAD MODE; every other case is NOP.
REQ-007 SHALL use a backing store of 2^(2+ROW_BITS+9) x 16 bits, indexed {BA, row[ROW_BITS-1:0], col[8:0]}.
REQ-008 SHALL decode LOAD MODE fields as follows:
- A[2:0] burst length: 0 gives BL 1, 1 gives 2, 2 gives 4, 3 gives 8, any other value gives 1.
- A[6:4] CAS latency: 2 gives CL 2, any other value gives CL 3.
- A9=1 selects single-location writes.
REQ-009 SHALL track an open flag and an open row per bank; ACTIVE sets both.
REQ-010 SHALL close the bank given by BA on PRECHARGE with A10=0, and close all banks with A10=1.
REQ-011 SHALL treat a READ sampled at edge N as follows: data beat k (k = 0..BL-1) is on dq_out during the cycle after edge N+CL-1+k.
REQ-012 SHALL generate column addresses sequentially, wrapping within the BL-aligned block; col 0x1E with BL 4 gives 1E, 1F, 1C, 1D.
REQ-013 SHALL store dq_in on the WRITE edge and the next BL-1 edges; bytes with DQM=1 on that edge are not written (write DQM latency 0).
REQ-014 SHALL apply read DQM with latency 2: DQM[b]=1 sampled at edge M forces dq_oe[b]=0 for the beat driven two cycles later.
REQ-015 SHALL let a new READ or WRITE truncate any burst in progress.
REQ-016 SHALL cancel pending read beats not yet driven when a WRITE arrives, and drive dq_oe=0 from that edge.
REQ-017 SHALL stop the current burst on BURST TERMINATE; read beats already in the CL pipeline still complete.
REQ-018 SHALL, on READ/WRITE with A10=1, close the bank after the last beat.
REQ-019 SHALL pulse protocol_err for:
- READ/WRITE to a closed bank; the access is then ignored.
- ACTIVE to an open bank; the row is unchanged.
- AUTO REFRESH while any bank is open.
- READ/WRITE before mode_set=1.
REQ-020 SHALL hold dq_out at 0 whenever dq_oe=0.

Reset
REQ-021 SHALL, when reset_n=0 at a rising edge:
- close all banks;
- set mode to BL 1, CL 3, burst writes;
- set mode_set=0, dq_oe=0, dq_out=0, protocol_err=0;
- flush the read pipeline and burst counters.
REQ-022 SHALL NOT clear backing-store contents on reset; a burst cut by reset is abandoned mid-burst.

Configuration
REQ-023 SHALL, with SDRAM_RESP_TIMING_CHECK_EN defined, count per-bank cycles and pulse protocol_err on any T_RCD, T_RP or T_RFC violation; the offending command is still executed.
REQ-024 SHALL, without SDRAM_RESP_TIMING_CHECK_EN, omit all timing counters and flag only the REQ-019 state errors.

Verification
REQ-025 SHALL cover: LOAD MODE A=0x033 -> mode_set=1; READ returns beats CL 3 cycles later with BL 8; no protocol_err.
REQ-026 SHALL cover: ACTIVE bank0 row 0x322, WRITE col 0x020 with 1234,5678,9ABC,DEF0,FEDC,BA98,7654,3210, READ col 0x020 -> the same eight words in order on dq_out, dq_oe=2'b11 for 8 cycles.
REQ-027 SHALL cover: CL 2 BL 4, READ col 0x01E -> columns 1E,1F,1C,1D; DQM=2'b10 at read edge+1 -> dq_oe=2'b01 on beat 1 only.
REQ-028 SHALL cover: WRITE BL 8 with DQM=2'b01 on beat 3, then read back -> beat 3 low byte keeps its old value.
REQ-029 SHALL cover: READ to closed bank 2 -> protocol_err pulse, dq_oe stays 0; READ interrupted by WRITE at edge N+1 -> no read beats driven.
REQ-030 SHALL cover: with SDRAM_RESP_TIMING_CHECK_EN, READ one cycle after ACTIVE (T_RCD=2) -> protocol_err; reset_n=0 mid-burst -> dq_oe=0 on the next cycle and mode_set=0.
